// File: rtl/sys_rst_seq_if.sv
// Board-level reset/control bundle for sys_rst_seq.
// slave: sequencer side; master: board/testbench side.
interface sys_rst_seq_if;
  logic       pll_locked_i;
  logic       btn_i;
  logic       wdt_kick_i;
  logic       srst_o;
  logic       run_o;
  logic       irq_o;
  logic [1:0] state_o;
  logic       wdt_flag_o;

  modport slave (
    input  pll_locked_i, btn_i, wdt_kick_i,
    output srst_o, run_o, irq_o, state_o, wdt_flag_o
  );

  modport master (
    output pll_locked_i, btn_i, wdt_kick_i,
    input  srst_o, run_o, irq_o, state_o, wdt_flag_o
  );
endinterface

// File: rtl/sys_rst_seq.sv
// System reset sequencer: PLL-lock qualified core reset, button debounce/irq.
// Ports: clk_i, arstn_i (async low), bus (sys_rst_seq_if.slave).
// Optional watchdog enabled by defining RST_SEQ_WDT_EN.
module sys_rst_seq #(
  parameter int LOCK_CYCLES     = 1024,
  parameter int RST_CYCLES      = 16,
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int WDT_CYCLES      = 16777216
) (
  input  logic         clk_i,
  input  logic         arstn_i,
  sys_rst_seq_if.slave bus
);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    HOLD      = 2'd2,
    RUN       = 2'd3
  } state_e;

  localparam int SEQ_MAX = (LOCK_CYCLES > RST_CYCLES) ?
                           LOCK_CYCLES : RST_CYCLES;
  localparam int SEQ_W = $clog2(SEQ_MAX + 1);
  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int WDT_W = $clog2(WDT_CYCLES + 1);

  localparam logic [SEQ_W-1:0] LOCK_LAST = SEQ_W'(LOCK_CYCLES - 1);
  localparam logic [SEQ_W-1:0] RST_LAST  = SEQ_W'(RST_CYCLES - 1);
  localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);

  // Async assert, sync deassert of the internal reset.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) rst_sync_q <= '0;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_n = rst_sync_q[1];

  logic [1:0] lock_sync_q;
  logic [1:0] btn_sync_q;
  logic       lock;
  logic       btn;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      lock_sync_q <= '0;
      btn_sync_q  <= '0;
    end else begin
      lock_sync_q <= {lock_sync_q[0], bus.pll_locked_i};
      btn_sync_q  <= {btn_sync_q[0], bus.btn_i};
    end
  end

  assign lock = lock_sync_q[1];
  assign btn  = btn_sync_q[1];

  state_e           state_q, state_d;
  logic [SEQ_W-1:0] cnt_q, cnt_d;
  logic [SEQ_W-1:0] cnt_inc;
  logic             srst_q, srst_d;
  logic             db_q, db_d;
  logic [DB_W-1:0]  dbc_q, dbc_d;
  logic             irq_q, irq_d;
  logic             wdt_expire;
  logic             wdt_flag;

  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + SEQ_W'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      WAIT_LOCK: begin
        cnt_d = '0;
        if (lock) state_d = STABLE;
      end
      STABLE: begin
        if (!lock) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == LOCK_LAST) begin
          state_d = HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      HOLD: begin
        if (!lock) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == RST_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      RUN: begin
        cnt_d = '0;
        if (!lock)           state_d = WAIT_LOCK;
        else if (wdt_expire) state_d = HOLD;
      end
      default: begin
        state_d = WAIT_LOCK;
        cnt_d   = '0;
      end
    endcase
    srst_d = (state_d != RUN);
  end

  // Outside RUN the debounced value shadows the synchronised button,
  // so a press begun before RUN can never surface as an edge later.
  always_comb begin
    db_d  = db_q;
    dbc_d = '0;
    if (state_q != RUN) begin
      db_d = btn;
    end else if (btn != db_q) begin
      if (dbc_q == DB_LAST) db_d = btn;
      else dbc_d = (dbc_q == '1) ? dbc_q : dbc_q + DB_W'(1);
    end
    irq_d = db_d & ~db_q & (state_q == RUN);
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= WAIT_LOCK;
      cnt_q   <= '0;
      srst_q  <= 1'b1;
      db_q    <= 1'b0;
      dbc_q   <= '0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      srst_q  <= srst_d;
      db_q    <= db_d;
      dbc_q   <= dbc_d;
      irq_q   <= irq_d;
    end
  end

`ifdef RST_SEQ_WDT_EN
  localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_CYCLES - 1);

  logic [WDT_W-1:0] wdt_q, wdt_d;
  logic             flag_q, flag_d;

  // A kick in the expiry cycle wins; lock loss still beats expiry.
  always_comb begin
    wdt_d      = '0;
    wdt_expire = 1'b0;
    flag_d     = flag_q;
    if (state_q == RUN) begin
      if (bus.wdt_kick_i) begin
        wdt_d = '0;
      end else if (wdt_q == WDT_LAST) begin
        wdt_expire = lock;
      end else begin
        wdt_d = (wdt_q == '1) ? wdt_q : wdt_q + WDT_W'(1);
      end
    end
    if (state_q == WAIT_LOCK) flag_d = 1'b0;
    else if (wdt_expire)      flag_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      wdt_q  <= '0;
      flag_q <= 1'b0;
    end else begin
      wdt_q  <= wdt_d;
      flag_q <= flag_d;
    end
  end

  assign wdt_flag = flag_q;
`else
  logic [WDT_W-1:0] unused_wdt;

  assign unused_wdt = {WDT_W{bus.wdt_kick_i}};
  assign wdt_expire = 1'b0;
  assign wdt_flag   = 1'b0;
`endif

  assign bus.srst_o     = srst_q;
  assign bus.run_o      = (state_q == RUN);
  assign bus.irq_o      = irq_q;
  assign bus.state_o    = state_q;
  assign bus.wdt_flag_o = wdt_flag;

endmodule

// File: doc/sys_rst_seq.md
SYS_RST_SEQ -- requirements
Module: sys_rst_seq

Interface
REQ-001 Parameter LOCK_CYCLES, default 1024: cycles pll_locked_i must stay high before core reset sequencing starts.
REQ-002 Parameter RST_CYCLES, default 16: cycles srst_o is held asserted after lock is stable.
REQ-003 Parameter DEBOUNCE_CYCLES, default 100000: cycles the synchronised button must be stable to be accepted.
REQ-004 Parameter WDT_CYCLES, default 16777216: watchdog timeout in cycles, used only when RST_SEQ_WDT_EN is defined.
REQ-005 clk_i  input  1  the single system clock; all logic is on its rising edge.
REQ-006 arstn_i  input  1  asynchronous active-low reset; assertion is asynchronous, deassertion is internally synchronised to clk_i.
REQ-007 pll_locked_i  input  1  PLL lock, asynchronous to clk_i.
REQ-008 btn_i  input  1  raw push-button, asynchronous, active-high.
REQ-009 wdt_kick_i  input  1  one-cycle watchdog restart strobe from software GPIO; ignored without RST_SEQ_WDT_EN.
REQ-010 srst_o  output  1  synchronous active-high core reset for the SoC.
REQ-011 run_o  output  1  high only in state RUN.
REQ-012 irq_o  output  1  one-cycle pulse on each accepted button press.
REQ-013 state_o  output  2  current state encoding: WAIT_LOCK=0, STABLE=1, HOLD=2, RUN=3.
REQ-014 wdt_flag_o  output  1  sticky flag: last core reset was caused by the watchdog.

Function
REQ-015 pll_locked_i and btn_i SHALL each pass a 2-flop synchroniser before use; all latencies below count from the synchronised value.
REQ-016 WAIT_LOCK: srst_o=1, counter cleared; synchronised lock high -> STABLE.
REQ-017 STABLE: srst_o=1, counter increments each cycle; lock low -> WAIT_LOCK; counter reaching LOCK_CYCLES-1 with lock high -> HOLD.
REQ-018 HOLD: srst_o=1, counter restarts from 0; after exactly RST_CYCLES cycles in HOLD -> RUN.
REQ-019 RUN: srst_o=0, run_o=1; lock low -> WAIT_LOCK with srst_o=1 on the next cycle.
REQ-020 Lock loss in any state SHALL take priority over every other transition, including watchdog expiry.
REQ-021 srst_o SHALL be a registered output, glitch-free, deasserted on the first cycle state_o reads RUN.
REQ-022 Debounce: counter resets on any change of the synchronised button versus the debounced value; after DEBOUNCE_CYCLES stable cycles the debounced value updates.
REQ-023 irq_o SHALL pulse for exactly one cycle on a debounced 0->1 transition and only while in RUN; presses outside RUN are dropped, not queued.
REQ-024 Holding the button SHALL produce one irq_o pulse; release SHALL produce none.
REQ-025 Counters SHALL saturate, never wrap; widths are sized with $clog2 of the largest relevant parameter.

Reset
REQ-026 While arstn_i=0: state WAIT_LOCK, srst_o=1, run_o=0, irq_o=0, state_o=0, wdt_flag_o=0, debounced button=0, all counters and synchronisers 0.
REQ-027 Reset asserted mid-sequence or mid-debounce SHALL abort immediately; no irq_o pulse is produced on reset release.

Configuration
REQ-028 Macro RST_SEQ_WDT_EN defined: in RUN a watchdog counter increments each cycle, clears on wdt_kick_i, and on reaching WDT_CYCLES-1 forces HOLD and sets wdt_flag_o.
REQ-029 With RST_SEQ_WDT_EN: wdt_flag_o clears only on arstn_i or on a lock-loss path through WAIT_LOCK; a kick in the expiry cycle wins over expiry.
REQ-030 Without RST_SEQ_WDT_EN: no watchdog logic, wdt_kick_i unused, wdt_flag_o tied 0.

Verification (LOCK_CYCLES=8, RST_CYCLES=4, DEBOUNCE_CYCLES=5, WDT_CYCLES=32)
REQ-031 arstn_i released, pll_locked_i=1 constant -> srst_o=1 throughout WAIT_LOCK/STABLE/HOLD; srst_o=0 and state_o=3 exactly 2+1+8+4 cycles after first synchronised edge budget, checked against a cycle-accurate model.
REQ-032 pll_locked_i drops for 1 cycle at STABLE count 5 -> state_o returns to 0, count restarts, full 8+4 sequence repeated.
REQ-033 In RUN, btn_i bounces 3 times at 2-cycle intervals then stays high 20 cycles -> exactly one irq_o pulse, 2+5 cycles after final edge.
REQ-034 btn_i pressed while state_o=2 and held into RUN -> no irq_o pulse.
REQ-035 With RST_SEQ_WDT_EN, no kicks in RUN -> state_o=2 after 32 cycles, wdt_flag_o=1, srst_o=1 for 4 cycles, RUN re-entered; kicks every 20 cycles -> remains in RUN.
REQ-036 arstn_i asserted in RUN mid-debounce -> all outputs at REQ-026 values in the same cycle, no irq_o after release.
